bos_pkt_tx: RTL and testbench
=============================

# bos_pkt_tx

Upstream packet framer for the bos UART link. It collects byte streams from the on-board channel endpoints, wraps each burst in the link frame and streams the framed bytes to the UART transmitter over a valid/ready byte interface. The frame is prefix 0xDD, source address, destination address, length, then payload. It sits between the per-channel output buffers (`ready_bus`/`data_bus`/`valid_bus` style) and the UART TX byte port, and mirrors the RX-side packet parser.

## Interface
- `N_CH`, 5: number of channel sources.
- `PREFIX`, 8'hDD: frame start byte.
- `BASE_ADDR`, 8'h01: address of channel 0; channel i uses BASE_ADDR+i as source address.
- `HOST_ADDR`, 8'h00: destination address written in every frame.

Ports:
- `fpga_clk_48`  in  1  system clock; all logic on rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `ch_data`  in  N_CH*8  payload byte per channel; channel i at [i*8+:8].
- `ch_valid`  in  N_CH  channel i byte valid.
- `ch_ready`  out  N_CH  byte accepted from channel i.
- `ch_count`  in  N_CH*8  bytes buffered per channel, 0..255, sampled only at arbitration.
- `tx_data`  out  8  byte to UART TX.
- `tx_valid`  out  1  tx_data valid.
- `tx_ready`  in  1  UART TX can accept a byte.
- `dbg_state`  out  3  FSM state encoding.
- `dbg_sel`  out  3  selected channel.
- `dbg_cnt`  out  8  payload bytes remaining.

## Operation
- Transfer rule: a byte moves on `tx_valid && tx_ready` at the clock edge. Channel i byte moves on `ch_valid[i] && ch_ready[i]`.
- FSM states: IDLE(0), PREFIX(1), SRC(2), DST(3), LEN(4), PAYLOAD(5).
- IDLE:
  - `tx_valid`=0, all `ch_ready`=0.
  - Round-robin search starts at pointer `rr`. The first channel with `ch_count`!=0 wins.
  - On a win: latch `sel`; latch `len`=`cnt`=`ch_count[sel]`; go to PREFIX.
  - On no win: stay in IDLE.
- PREFIX, SRC, DST, LEN:
  - `tx_valid`=1.
  - `tx_data` is PREFIX, BASE_ADDR+sel, HOST_ADDR and len respectively.
  - Advance to the next state on a transfer; otherwise hold, with data stable.
- PAYLOAD:
  - `tx_data`=`ch_data[sel]`, `tx_valid`=`ch_valid[sel]`, `ch_ready[sel]`=`tx_ready`; all other `ch_ready`=0. This is a combinational pass-through with no buffering.
  - `cnt` decrements on each transfer.
  - The transfer with `cnt`==1 returns to IDLE and sets `rr`=(sel+1) mod N_CH.
- Length is frozen at arbitration. Bytes that arrive later in the same channel go in a later frame. `ch_count` changes during a frame are ignored.
- `ch_valid[sel]` dropping mid-payload stalls the frame: `tx_valid`=0, state held, no timeout.
- `tx_ready` held low freezes every state with outputs stable. This satisfies the valid/ready rule that `tx_valid` is never withdrawn in header states.
- `rr` wraps N_CH-1 -> 0. A lone requester is reselected each frame.
- Reset, asynchronous, including mid-frame:
  - State IDLE, `rr`=0, `sel`=0, `len`=`cnt`=0.
  - `tx_valid`=0, `tx_data`=0, `ch_ready`=0.
  - A partial frame is abandoned; the downstream parser resynchronises on the next PREFIX.

## Timing
- IDLE->PREFIX takes 1 cycle after `ch_count`!=0 is seen. `tx_valid` rises on the cycle following the arbitration edge.
- With `tx_ready` and `ch_valid` held high, a frame of L bytes occupies 4+L consecutive transfer cycles.
- One IDLE cycle separates consecutive frames.
- Header outputs are registered, from state and latched regs. Payload outputs are combinational from `ch_*` and `tx_ready`.

## Test plan
- Single frame: `ch_count[2]`=3, bytes 0xA1,0xA2,0xA3, `tx_ready`=1.
  - -> tx sequence DD,03,00,03,A1,A2,A3, with `ch_ready[2]` high for exactly 3 transfers.
  - -> state returns to IDLE and `rr`=3.
- Round robin: channels 0 and 4 both request 1 byte each, `rr`=0.
  - -> frames leave in order src 01 then src 05, with one IDLE cycle between them.
  - -> a second request on channel 0 issued during the first frame is served after channel 4.
- Backpressure: `tx_ready` toggled 1-cycle on/2-cycles off across a 2-byte frame.
  - -> same 6-byte sequence; `tx_data`/`tx_valid` stable while stalled; no byte duplicated or lost.
- Source stall: `ch_valid[1]` low for 10 cycles after the first of 4 payload bytes.
  - -> `tx_valid`=0 for those 10 cycles, state PAYLOAD, `dbg_cnt`=3, then the frame completes.
- Count snapshot: `ch_count[3]` goes 2 -> 5 one cycle after arbitration.
  - -> LEN byte=02, two payload bytes, then a new frame with LEN=03.
- Reset mid-payload: assert `n_rst`=0 after the 2nd of 6 payload bytes.
  - -> outputs zero immediately, without waiting for a clock edge.
  - -> after release, the next frame starts with DD and source address BASE_ADDR+0 order from `rr`=0.

Source files
------------

// File: rtl/bos_pkt_tx.sv
// bos_pkt_tx: upstream packet framer for the bos UART link.
//
// Picks one channel at a time by round robin, among the channels whose
// buffered byte count is non-zero. It then emits one frame:
//   PREFIX, BASE_ADDR+sel, HOST_ADDR, len, then len payload bytes.
// The length is frozen when the channel is picked. Payload bytes pass
// straight from the selected channel to the UART TX port, with no buffering.
//
// Ports
//   fpga_clk_48  system clock, rising edge
//   n_rst        asynchronous active-low reset
//   ch_data      payload byte per channel, channel i at [i*8+:8]
//   ch_valid     per-channel byte valid
//   ch_ready     per-channel byte accepted (only the selected channel, in payload)
//   ch_count     per-channel buffered byte count, sampled only while idle
//   tx_data      byte to UART TX
//   tx_valid     tx_data valid
//   tx_ready     UART TX can accept a byte
//   dbg_state    FSM state encoding
//   dbg_sel      selected channel
//   dbg_cnt      payload bytes remaining in the current frame
module bos_pkt_tx #(
    parameter int         N_CH      = 5,
    parameter logic [7:0] PREFIX    = 8'hDD,
    parameter logic [7:0] BASE_ADDR = 8'h01,
    parameter logic [7:0] HOST_ADDR = 8'h00
) (
    input  logic              fpga_clk_48,
    input  logic              n_rst,
    input  logic [N_CH*8-1:0] ch_data,
    input  logic [N_CH-1:0]   ch_valid,
    output logic [N_CH-1:0]   ch_ready,
    input  logic [N_CH*8-1:0] ch_count,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [2:0]        dbg_state,
    output logic [2:0]        dbg_sel,
    output logic [7:0]        dbg_cnt
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PREFIX  = 3'd1,
        S_SRC     = 3'd2,
        S_DST     = 3'd3,
        S_LEN     = 3'd4,
        S_PAYLOAD = 3'd5
    } state_t;

    state_t     state, state_n;
    logic [2:0] rr, rr_n;
    logic [2:0] sel, sel_n;
    logic [7:0] len, len_n;
    logic [7:0] cnt, cnt_n;

    logic       win;
    logic [2:0] win_idx;
    int         idx;

    // Round-robin search: the first non-empty channel, starting at rr, wins.
    always_comb begin
        win     = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int k = 0; k < N_CH; k++) begin
            idx = (int'(rr) + k) % N_CH;
            if (!win && ch_count[idx*8 +: 8] != 8'd0) begin
                win     = 1'b1;
                win_idx = 3'(idx);
            end
        end
    end

    always_ff @(posedge fpga_clk_48 or negedge n_rst) begin
        if (!n_rst) begin
            state <= S_IDLE;
            rr    <= '0;
            sel   <= '0;
            len   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            rr    <= rr_n;
            sel   <= sel_n;
            len   <= len_n;
            cnt   <= cnt_n;
        end
    end

    // Header bytes depend only on state and latched registers. The payload
    // path is a pure combinational pass-through of the selected channel.
    always_comb begin
        state_n  = state;
        rr_n     = rr;
        sel_n    = sel;
        len_n    = len;
        cnt_n    = cnt;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        ch_ready = '0;
        case (state)
            S_IDLE: begin
                if (win) begin
                    sel_n   = win_idx;
                    len_n   = ch_count[int'(win_idx)*8 +: 8];
                    cnt_n   = ch_count[int'(win_idx)*8 +: 8];
                    state_n = S_PREFIX;
                end
            end
            S_PREFIX: begin
                tx_valid = 1'b1;
                tx_data  = PREFIX;
                if (tx_ready) state_n = S_SRC;
            end
            S_SRC: begin
                tx_valid = 1'b1;
                tx_data  = BASE_ADDR + {5'd0, sel};
                if (tx_ready) state_n = S_DST;
            end
            S_DST: begin
                tx_valid = 1'b1;
                tx_data  = HOST_ADDR;
                if (tx_ready) state_n = S_LEN;
            end
            S_LEN: begin
                tx_valid = 1'b1;
                tx_data  = len;
                if (tx_ready) state_n = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                tx_data       = ch_data[int'(sel)*8 +: 8];
                tx_valid      = ch_valid[sel];
                ch_ready[sel] = tx_ready;
                if (ch_valid[sel] && tx_ready) begin
                    cnt_n = cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state_n = S_IDLE;
                        rr_n    = (sel == 3'(N_CH - 1)) ? 3'd0 : sel + 3'd1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign dbg_state = state;
    assign dbg_sel   = sel;
    assign dbg_cnt   = cnt;

endmodule

// File: tb/tb_bos_pkt_tx.sv
// Testbench for bos_pkt_tx.
// Each channel source is a byte queue. ch_count follows the queue depth.
// Expected frame streams come from a round-robin frame model that works on
// the queue contents, or from literal sequences.
module tb_bos_pkt_tx;
    localparam int N = 5;

    logic            fpga_clk_48 = 1'b0;
    logic            n_rst;
    logic [N*8-1:0]  ch_data;
    logic [N-1:0]    ch_valid;
    logic [N-1:0]    ch_ready;
    logic [N*8-1:0]  ch_count;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic [2:0]      dbg_state;
    logic [2:0]      dbg_sel;
    logic [7:0]      dbg_cnt;

    bos_pkt_tx dut (
        .fpga_clk_48(fpga_clk_48), .n_rst(n_rst),
        .ch_data(ch_data), .ch_valid(ch_valid), .ch_ready(ch_ready),
        .ch_count(ch_count), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .dbg_state(dbg_state), .dbg_sel(dbg_sel),
        .dbg_cnt(dbg_cnt)
    );

    always #5 fpga_clk_48 = ~fpga_clk_48;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          model_rr = 0;
    logic [7:0]  src_q [N][$];
    logic [7:0]  obs_q [$];
    int          obs_t [$];
    logic [7:0]  exp_q [$];
    int          pops [N];
    logic [N-1:0] stall = '0;
    bit          rand_mode = 1'b0;

    logic        s_valid, s_ready;
    logic [7:0]  s_data, s_cnt;
    logic [2:0]  s_state;
    logic [N-1:0] s_chr;

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            ch_valid[i] = (src_q[i].size() != 0) && !stall[i];
            ch_data[i*8 +: 8] = (src_q[i].size() != 0) ? src_q[i][0] : 8'h00;
            ch_count[i*8 +: 8] = (src_q[i].size() > 255) ? 8'd255 : 8'(src_q[i].size());
        end
    endtask

    // Sample on the falling edge, then apply source pops just after the rising edge.
    task automatic step();
        logic [N-1:0] xfer;
        @(negedge fpga_clk_48);
        s_valid = tx_valid; s_data = tx_data; s_ready = tx_ready;
        s_state = dbg_state; s_cnt = dbg_cnt; s_chr = ch_ready;
        if (tx_valid && tx_ready) begin
            obs_q.push_back(tx_data);
            obs_t.push_back(cyc);
        end
        xfer = ch_valid & ch_ready;
        @(posedge fpga_clk_48);
        #1;
        cyc++;
        for (int i = 0; i < N; i++)
            if (xfer[i]) begin
                src_q[i].delete(0);
                pops[i]++;
            end
        if (rand_mode) begin
            tx_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) stall[i] = ($urandom_range(0, 4) == 0);
        end
        drive();
    endtask

    task automatic load(input int ch, input int n);
        for (int b = 0; b < n; b++) src_q[ch].push_back(8'($urandom));
    endtask

    task automatic clear_obs();
        obs_q.delete(); obs_t.delete(); exp_q.delete();
    endtask

    // Reference: serve every currently queued channel in round-robin order.
    // Each channel sends one frame that carries its whole queue.
    task automatic model_frames();
        int  size_m [N];
        int  c;
        bit  found;
        c = 0;
        for (int i = 0; i < N; i++) size_m[i] = src_q[i].size();
        found = 1'b1;
        while (found) begin
            found = 1'b0;
            for (int k = 0; k < N && !found; k++)
                if (size_m[(model_rr + k) % N] != 0) begin
                    c = (model_rr + k) % N;
                    found = 1'b1;
                end
            if (found) begin
                exp_q.push_back(8'hDD);
                exp_q.push_back(8'(8'h01 + c));
                exp_q.push_back(8'h00);
                exp_q.push_back(8'(size_m[c]));
                for (int b = 0; b < size_m[c]; b++) exp_q.push_back(src_q[c][b]);
                size_m[c] = 0;
                model_rr = (c + 1) % N;
            end
        end
    endtask

    task automatic run_frames(input int n, input int budget);
        bit done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            step();
            if (obs_q.size() >= n && dbg_state == 3'd0) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout: got %0d bytes, expected %0d", obs_q.size(), n);
        end
    endtask

    task automatic reset_dut();
        n_rst = 1'b0;
        repeat (2) @(posedge fpga_clk_48);
        #1;
        n_rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            pops[i] = 0;
        end
        stall = '0;
        model_rr = 0;
        tx_ready = 1'b1;
        drive();
        clear_obs();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge fpga_clk_48);
        #1;
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || ch_ready !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%02h ready=%b expected 0/00/0", tx_valid, tx_data, ch_ready);
        end
        checks++;
        if (dbg_state !== 3'd0 || dbg_sel !== 3'd0 || dbg_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_dbg: got state=%0d sel=%0d cnt=%0d expected 0/0/0", dbg_state, dbg_sel, dbg_cnt);
        end
        n_rst = 1'b1;
        repeat (4) begin
            step();
            checks++;
            if (s_state !== 3'd0 || s_valid !== 1'b0 || s_chr !== '0) begin
                errors++;
                $display("FAIL idle_no_req: got state=%0d valid=%b expected IDLE, 0", s_state, s_valid);
            end
        end
    endtask

    task automatic test_single_frame();
        int nchr = 0;
        bit done = 1'b0;
        clear_obs();
        src_q[2].push_back(8'hA1); src_q[2].push_back(8'hA2); src_q[2].push_back(8'hA3);
        drive();
        exp_q = '{8'hDD, 8'h03, 8'h00, 8'h03, 8'hA1, 8'hA2, 8'hA3};
        for (int k = 0; k < 60 && !done; k++) begin
            step();
            if (s_chr[2]) nchr++;
            if (obs_q.size() >= 7 && dbg_state == 3'd0) done = 1'b1;
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL single_len: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL single_byte[%0d]: got %02h expected %02h", k, obs_q[k], exp_q[k]);
            end
        end
        checks++;
        if (nchr !== 3 || pops[2] !== 3) begin
            errors++;
            $display("FAIL single_ch_ready: got %0d cycles/%0d pops expected 3/3", nchr, pops[2]);
        end
        if (obs_t.size() >= 7) begin
            checks++;
            if (obs_t[6] - obs_t[0] !== 6) begin
                errors++;
                $display("FAIL single_span: got %0d cycles expected 6", obs_t[6] - obs_t[0]);
            end
        end
        // rr now points at channel 3: channel 3 must beat channel 0.
        model_rr = 3;
        clear_obs();
        load(0, 1); load(3, 1);
        model_frames();
        drive();
        run_frames(exp_q.size(), 100);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL rr3_len: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL rr3_byte[%0d]: got %02h expected %02h", k, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] a, b, c;
        bit pushed = 1'b0;
        bit done = 1'b0;
        reset_dut();
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
        src_q[0].push_back(a); src_q[4].push_back(b);
        drive();
        exp_q = '{8'hDD, 8'h01, 8'h00, 8'h01, a,
                  8'hDD, 8'h05, 8'h00, 8'h01, b,
                  8'hDD, 8'h01, 8'h00, 8'h01, c};
        for (int k = 0; k < 100 && !done; k++) begin
            step();
            if (!pushed && dbg_state == 3'd1) begin
                src_q[0].push_back(c);
                drive();
                pushed = 1'b1;
            end
            if (obs_q.size() >= 15 && dbg_state == 3'd0) done = 1'b1;
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL rr_len: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL rr_byte[%0d]: got %02h expected %02h", k, obs_q[k], exp_q[k]);
            end
        end
        if (obs_t.size() >= 11) begin
            checks++;
            if (obs_t[5] - obs_t[4] !== 2 || obs_t[10] - obs_t[9] !== 2) begin
                errors++;
                $display("FAIL rr_gap: got %0d,%0d expected 2,2", obs_t[5] - obs_t[4], obs_t[10] - obs_t[9]);
            end
        end
        model_rr = 1;
    endtask

    task automatic test_backpressure();
        logic       p_valid, p_ready;
        logic [7:0] p_data;
        int         nstall = 0;
        bit         done = 1'b0;
        clear_obs();
        load(1, 2);
        model_frames();
        drive();
        p_valid = 1'b0; p_ready = 1'b1; p_data = 8'h00;
        for (int k = 0; k < 200 && !done; k++) begin
            tx_ready = (k % 3 == 0);
            step();
            if (p_valid && !p_ready) begin
                nstall++;
                checks++;
                if (s_valid !== 1'b1 || s_data !== p_data) begin
                    errors++;
                    $display("FAIL bp_hold: got valid=%b data=%02h expected 1/%02h", s_valid, s_data, p_data);
                end
            end
            p_valid = s_valid; p_ready = s_ready; p_data = s_data;
            if (obs_q.size() >= 6 && dbg_state == 3'd0) done = 1'b1;
        end
        tx_ready = 1'b1;
        checks++;
        if (nstall < 6) begin
            errors++;
            $display("FAIL bp_stalls: got %0d stalled cycles expected at least 6", nstall);
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL bp_len: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL bp_byte[%0d]: got %02h expected %02h", k, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_source_stall();
        bit hit = 1'b0;
        clear_obs();
        pops[1] = 0;
        load(1, 4);
        model_frames();
        drive();
        for (int k = 0; k < 50 && !hit; k++) begin
            step();
            if (pops[1] == 1) hit = 1'b1;
        end
        stall[1] = 1'b1;
        drive();
        repeat (10) begin
            step();
            checks++;
            if (s_valid !== 1'b0 || s_state !== 3'd5 || s_cnt !== 8'd3) begin
                errors++;
                $display("FAIL src_stall: got valid=%b state=%0d cnt=%0d expected 0/5/3", s_valid, s_state, s_cnt);
            end
        end
        stall[1] = 1'b0;
        drive();
        run_frames(exp_q.size(), 100);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL stall_len: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL stall_byte[%0d]: got %02h expected %02h", k, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_count_snapshot();
        logic [7:0] u, v, w, x, y;
        bit pushed = 1'b0;
        clear_obs();
        u = 8'($urandom); v = 8'($urandom); w = 8'($urandom); x = 8'($urandom); y = 8'($urandom);
        src_q[3].push_back(u); src_q[3].push_back(v);
        drive();
        exp_q = '{8'hDD, 8'h04, 8'h00, 8'h02, u, v,
                  8'hDD, 8'h04, 8'h00, 8'h03, w, x, y};
        for (int k = 0; k < 20 && !pushed; k++) begin
            step();
            if (dbg_state == 3'd1) begin
                src_q[3].push_back(w); src_q[3].push_back(x); src_q[3].push_back(y);
                drive();
                pushed = 1'b1;
            end
        end
        run_frames(exp_q.size(), 100);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL snap_len: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL snap_byte[%0d]: got %02h expected %02h", k, obs_q[k], exp_q[k]);
            end
        end
        model_rr = 4;
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        clear_obs();
        pops[2] = 0;
        load(2, 6);
        drive();
        for (int k = 0; k < 50 && !hit; k++) begin
            step();
            if (pops[2] == 2) hit = 1'b1;
        end
        load(0, 1); load(4, 1);
        drive();
        n_rst = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || ch_ready !== '0) begin
            errors++;
            $display("FAIL async_rst_out: got valid=%b data=%02h ready=%b expected 0/00/0", tx_valid, tx_data, ch_ready);
        end
        checks++;
        if (dbg_state !== 3'd0 || dbg_sel !== 3'd0 || dbg_cnt !== 8'd0) begin
            errors++;
            $display("FAIL async_rst_dbg: got state=%0d sel=%0d cnt=%0d expected 0/0/0", dbg_state, dbg_sel, dbg_cnt);
        end
        repeat (2) @(posedge fpga_clk_48);
        #1;
        n_rst = 1'b1;
        clear_obs();
        model_rr = 0;
        model_frames();
        run_frames(exp_q.size(), 200);
        checks++;
        if (obs_q.size() < 2 || obs_q[0] !== 8'hDD || obs_q[1] !== 8'h01) begin
            errors++;
            $display("FAIL post_rst_first: got %0d bytes expected DD 01 first", obs_q.size());
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL post_rst_len: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL post_rst_byte[%0d]: got %02h expected %02h", k, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_random();
        bit any;
        for (int r = 0; r < 6; r++) begin
            clear_obs();
            any = 1'b0;
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 1) == 1) begin
                    load(c, $urandom_range(1, 6));
                    any = 1'b1;
                end
            if (!any) load($urandom_range(0, N - 1), 3);
            model_frames();
            drive();
            rand_mode = 1'b1;
            run_frames(exp_q.size(), 2000);
            rand_mode = 1'b0;
            stall = '0;
            tx_ready = 1'b1;
            drive();
            checks++;
            if (obs_q.size() !== exp_q.size()) begin
                errors++;
                $display("FAIL rand%0d_len: got %0d expected %0d", r, obs_q.size(), exp_q.size());
            end
            for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
                checks++;
                if (obs_q[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL rand%0d_byte[%0d]: got %02h expected %02h", r, k, obs_q[k], exp_q[k]);
                end
            end
        end
    endtask

    initial begin
        n_rst = 1'b0;
        tx_ready = 1'b1;
        for (int i = 0; i < N; i++) pops[i] = 0;
        drive();
        test_reset();
        test_single_frame();
        test_round_robin();
        test_backpressure();
        test_source_stall();
        test_count_snapshot();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
